uart_fifo: RTL

Parametrised UART successor for the CPU-side serial port: a single-clock block with a configurable bit period, word width and stop bits. It adds receive and transmit FIFOs so the CPU can queue bytes rather than hold one byte per direction. It also adds a start-bit glitch filter and sticky framing and overrun error flags. It sits between the FPGA serial pins and the CPU memory-mapped I/O decode.

---
 rtl/uart_fifo.sv | 389 ++++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo.sv
// uart_fifo: single-clock UART with TX/RX FIFOs, start-bit glitch filter and
// sticky framing/overrun flags.
// Optional even parity is enabled by defining UART_PARITY_EN; this adds the
// parity_err output and one extra bit period per frame.
module uart_fifo #(
  parameter int unsigned CLKS_PER_BIT = 234,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 full_clk,
  input  logic                 rst_n,
  input  logic                 uart_rx,
  output logic                 uart_tx,
  input  logic [DATA_BITS-1:0] send_in,
  input  logic                 set_send,
  input  logic                 set_recv_clear,
  output logic [DATA_BITS-1:0] recv_out,
  output logic                 get_recv,
  output logic                 send_full,
  output logic                 tx_busy,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef UART_PARITY_EN
  output logic                 parity_err,
`endif
  input  logic                 clear_err
);

  localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW  = $clog2(DATA_BITS);
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;

  localparam logic [CntW-1:0] CntLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf  = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BitW-1:0] BitLast  = BitW'(DATA_BITS - 1);
  localparam logic [1:0]      StopLast = 2'(STOP_BITS - 1);

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop, RxBreak} rx_state_e;

  // ---------------------------------------------------------------- TX FIFO
  logic [DATA_BITS-1:0] r_tx_mem [FIFO_DEPTH];
  logic [PtrW-1:0]      r_tx_wptr, r_tx_rptr;
  logic                 w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;
  logic [DATA_BITS-1:0] w_tx_head;

  assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
  assign w_tx_full  = (r_tx_wptr[AddrW] != r_tx_rptr[AddrW]) &&
                      (r_tx_wptr[AddrW-1:0] == r_tx_rptr[AddrW-1:0]);
  assign w_tx_push  = set_send && !w_tx_full;
  assign w_tx_head  = r_tx_mem[r_tx_rptr[AddrW-1:0]];
  assign send_full  = w_tx_full;

  // TX FIFO storage write
  always_ff @(posedge full_clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr[AddrW-1:0]] <= send_in;
  end

  // TX FIFO pointers
  always_ff @(posedge full_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + PtrW'(1);
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + PtrW'(1);
    end
  end

  // ---------------------------------------------------------------- TX FSM
  tx_state_e            r_tx_state, w_tx_state;
  logic [CntW-1:0]      r_tx_cnt, w_tx_cnt;
  logic [BitW-1:0]      r_tx_bit, w_tx_bit;
  logic [1:0]           r_tx_stop, w_tx_stop;
  logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift;
  logic                 r_tx, w_tx_line;
  logic                 w_tx_done;
`ifdef UART_PARITY_EN
  logic                 r_tx_par, w_tx_par;
`endif

  assign w_tx_done = (r_tx_cnt == CntLast);
  assign uart_tx   = r_tx;
  assign tx_busy   = !w_tx_empty || (r_tx_state != TxIdle);

  // TX state register; line is registered so reset forces it high at once
  always_ff @(posedge full_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TxIdle;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_stop  <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
`ifdef UART_PARITY_EN
      r_tx_par   <= 1'b0;
`endif
    end else begin
      r_tx_state <= w_tx_state;
      r_tx_cnt   <= w_tx_cnt;
      r_tx_bit   <= w_tx_bit;
      r_tx_stop  <= w_tx_stop;
      r_tx_shift <= w_tx_shift;
      r_tx       <= w_tx_line;
`ifdef UART_PARITY_EN
      r_tx_par   <= w_tx_par;
`endif
    end
  end

  // TX next state, FIFO pop and line level
  always_comb begin
    w_tx_state = r_tx_state;
    w_tx_cnt   = r_tx_cnt;
    w_tx_bit   = r_tx_bit;
    w_tx_stop  = r_tx_stop;
    w_tx_shift = r_tx_shift;
    w_tx_pop   = 1'b0;
    w_tx_line  = 1'b1;
`ifdef UART_PARITY_EN
    w_tx_par   = r_tx_par;
`endif
    case (r_tx_state)
      TxIdle: begin
        if (!w_tx_empty) begin
          w_tx_pop   = 1'b1;
          w_tx_shift = w_tx_head;
`ifdef UART_PARITY_EN
          w_tx_par   = ^w_tx_head;
`endif
          w_tx_cnt   = '0;
          w_tx_state = TxStart;
        end
      end
      TxStart: begin
        w_tx_line = 1'b0;
        if (w_tx_done) begin
          w_tx_cnt   = '0;
          w_tx_bit   = '0;
          w_tx_state = TxData;
        end else begin
          w_tx_cnt = r_tx_cnt + CntW'(1);
        end
      end
      TxData: begin
        w_tx_line = r_tx_shift[0];
        if (w_tx_done) begin
          w_tx_cnt   = '0;
          w_tx_shift = r_tx_shift >> 1;
          if (r_tx_bit == BitLast) begin
            w_tx_stop = '0;
`ifdef UART_PARITY_EN
            w_tx_state = TxParity;
`else
            w_tx_state = TxStop;
`endif
          end else begin
            w_tx_bit = r_tx_bit + BitW'(1);
          end
        end else begin
          w_tx_cnt = r_tx_cnt + CntW'(1);
        end
      end
`ifdef UART_PARITY_EN
      TxParity: begin
        w_tx_line = r_tx_par;
        if (w_tx_done) begin
          w_tx_cnt   = '0;
          w_tx_state = TxStop;
        end else begin
          w_tx_cnt = r_tx_cnt + CntW'(1);
        end
      end
`endif
      TxStop: begin
        if (w_tx_done) begin
          w_tx_cnt = '0;
          if (r_tx_stop == StopLast) begin
            // Chain straight into the next frame so queued bytes have no gap
            if (!w_tx_empty) begin
              w_tx_pop   = 1'b1;
              w_tx_shift = w_tx_head;
`ifdef UART_PARITY_EN
              w_tx_par   = ^w_tx_head;
`endif
              w_tx_state = TxStart;
            end else begin
              w_tx_state = TxIdle;
            end
          end else begin
            w_tx_stop = r_tx_stop + 2'd1;
          end
        end else begin
          w_tx_cnt = r_tx_cnt + CntW'(1);
        end
      end
      default: w_tx_state = TxIdle;
    endcase
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [DATA_BITS-1:0] r_rx_mem [FIFO_DEPTH];
  logic [PtrW-1:0]      r_rx_wptr, r_rx_rptr;
  logic                 w_rx_empty, w_rx_full, w_rx_push, w_rx_pop;
  logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift;

  assign w_rx_empty = (r_rx_wptr == r_rx_rptr);
  assign w_rx_full  = (r_rx_wptr[AddrW] != r_rx_rptr[AddrW]) &&
                      (r_rx_wptr[AddrW-1:0] == r_rx_rptr[AddrW-1:0]);
  assign w_rx_pop   = set_recv_clear && !w_rx_empty;
  assign get_recv   = !w_rx_empty;
  assign recv_out   = w_rx_empty ? '0 : r_rx_mem[r_rx_rptr[AddrW-1:0]];

  // RX FIFO storage write
  always_ff @(posedge full_clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr[AddrW-1:0]] <= r_rx_shift;
  end

  // RX FIFO pointers
  always_ff @(posedge full_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + PtrW'(1);
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + PtrW'(1);
    end
  end

  // ---------------------------------------------------------------- RX FSM
  logic            r_rx_meta, r_rx_sync;
  rx_state_e       r_rx_state, w_rx_state;
  logic [CntW-1:0] r_rx_cnt, w_rx_cnt;
  logic [BitW-1:0] r_rx_bit, w_rx_bit;
  logic            w_rx_done, w_frame_set, w_overrun_set;
  logic            r_frame_err, r_overrun;
`ifdef UART_PARITY_EN
  logic            r_rx_par_bad, w_rx_par_bad, w_par_set, r_parity_err;
  assign parity_err = r_parity_err;
`endif

  assign w_rx_done = (r_rx_cnt == CntLast);
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

  // Two-flop synchroniser for the asynchronous serial input
  always_ff @(posedge full_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // RX state register
  always_ff @(posedge full_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state   <= RxIdle;
      r_rx_cnt     <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
`ifdef UART_PARITY_EN
      r_rx_par_bad <= 1'b0;
`endif
    end else begin
      r_rx_state   <= w_rx_state;
      r_rx_cnt     <= w_rx_cnt;
      r_rx_bit     <= w_rx_bit;
      r_rx_shift   <= w_rx_shift;
`ifdef UART_PARITY_EN
      r_rx_par_bad <= w_rx_par_bad;
`endif
    end
  end

  // RX next state, sampling and push/error decisions
  always_comb begin
    w_rx_state    = r_rx_state;
    w_rx_cnt      = r_rx_cnt;
    w_rx_bit      = r_rx_bit;
    w_rx_shift    = r_rx_shift;
    w_rx_push     = 1'b0;
    w_frame_set   = 1'b0;
    w_overrun_set = 1'b0;
`ifdef UART_PARITY_EN
    w_rx_par_bad  = r_rx_par_bad;
    w_par_set     = 1'b0;
`endif
    case (r_rx_state)
      RxIdle: begin
        if (!r_rx_sync) begin
          w_rx_cnt   = '0;
          w_rx_state = RxStart;
        end
      end
      RxStart: begin
        // Mid-bit recheck rejects short low glitches
        if (r_rx_cnt == CntHalf) begin
          if (r_rx_sync) begin
            w_rx_state = RxIdle;
          end else begin
            w_rx_cnt   = '0;
            w_rx_bit   = '0;
            w_rx_state = RxData;
          end
        end else begin
          w_rx_cnt = r_rx_cnt + CntW'(1);
        end
      end
      RxData: begin
        if (w_rx_done) begin
          w_rx_cnt   = '0;
          w_rx_shift = {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
          if (r_rx_bit == BitLast) begin
`ifdef UART_PARITY_EN
            w_rx_state = RxParity;
`else
            w_rx_state = RxStop;
`endif
          end else begin
            w_rx_bit = r_rx_bit + BitW'(1);
          end
        end else begin
          w_rx_cnt = r_rx_cnt + CntW'(1);
        end
      end
`ifdef UART_PARITY_EN
      RxParity: begin
        if (w_rx_done) begin
          w_rx_cnt     = '0;
          w_rx_par_bad = r_rx_sync ^ (^r_rx_shift);
          w_rx_state   = RxStop;
        end else begin
          w_rx_cnt = r_rx_cnt + CntW'(1);
        end
      end
`endif
      RxStop: begin
        if (w_rx_done) begin
          w_rx_cnt = '0;
          if (r_rx_sync) begin
            w_rx_state = RxIdle;
`ifdef UART_PARITY_EN
            if (r_rx_par_bad) w_par_set = 1'b1;
            else
`endif
            // A same-cycle pop frees a slot, so a full FIFO still accepts
            if (w_rx_full && !w_rx_pop) w_overrun_set = 1'b1;
            else                        w_rx_push     = 1'b1;
          end else begin
            w_frame_set = 1'b1;
            w_rx_state  = RxBreak;
          end
        end else begin
          w_rx_cnt = r_rx_cnt + CntW'(1);
        end
      end
      RxBreak: begin
        if (r_rx_sync) w_rx_state = RxIdle;
      end
      default: w_rx_state = RxIdle;
    endcase
  end

  // Sticky error flags; a new error wins over a same-cycle clear
  always_ff @(posedge full_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef UART_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      if (w_frame_set)    r_frame_err <= 1'b1;
      else if (clear_err) r_frame_err <= 1'b0;
      if (w_overrun_set)  r_overrun   <= 1'b1;
      else if (clear_err) r_overrun   <= 1'b0;
`ifdef UART_PARITY_EN
      if (w_par_set)      r_parity_err <= 1'b1;
      else if (clear_err) r_parity_err <= 1'b0;
`endif
    end
  end

endmodule
